noc_mem_endpoint: RTL and testbench



---
 rtl/noc_mem_endpoint.sv | 152 +++++++++++++++
 tb/tb_noc_mem_endpoint.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_mem_endpoint.sv
// noc_mem_endpoint: memory-side ejection endpoint of the core-to-memory NoC.
// Buffers request packets in a small FIFO and serializes them through an
// IDLE -> ACCESS -> RESP sequence against a local word memory. Each request
// produces one response packet on the memory-to-core inject port.
module noc_mem_endpoint #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 128,
    parameter int DEPTH         = 2,
    parameter int SRC_WIDTH     = 2,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int MEM_DEPTH     = 256
) (
    input  logic                           clk,
    input  logic                           rst_l,
    input  logic                           FIFO_ENQ,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] FIFO_IN,
    output logic                           FIFO_FULL,
    output logic                           RESP_ENQ,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] RESP_OUT,
    input  logic                           RESP_FULL
);

    localparam int PKT_W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic                     wr;
        logic [SRC_WIDTH-1:0]     src;
        logic [MEM_AW-1:0]        addr;
        logic [PAYLOAD_WIDTH-1:0] wdata;
    } req_t;

    // Input FIFO storage and bookkeeping
    logic [PKT_W-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             fifo_empty, enq_ok, deq;
    logic [PKT_W-1:0] head;
    logic             unused_head;

    // Sequencer, request capture and memory
    state_t                   state_q, state_d;
    req_t                     req_q, req_d;
    logic [PAYLOAD_WIDTH-1:0] rdata_q;
    logic [PAYLOAD_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]    resp_data;
    logic                     resp_enq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full comes straight from the registered count, so an enq on a full
    // FIFO is dropped even when a dequeue happens in the same cycle.
    assign FIFO_FULL  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign enq_ok     = FIFO_ENQ && !FIFO_FULL;
    assign head       = fifo_mem[rd_ptr_q];
    // Upper address bits and spare data bits of the head are don't-care.
    assign unused_head = ^head;

    // Request decode of the FIFO head
    always_comb begin
        req_d       = '0;
        req_d.wr    = head[DATA_WIDTH-1];
        req_d.src   = head[DATA_WIDTH-2 -: SRC_WIDTH];
        req_d.addr  = head[DATA_WIDTH +: MEM_AW];
        req_d.wdata = head[PAYLOAD_WIDTH-1:0];
    end

    // FIFO payload storage; contents need no reset
    always_ff @(posedge clk) begin
        if (enq_ok)
            fifo_mem[wr_ptr_q] <= FIFO_IN;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (deq)    rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(enq_ok) - CW'(deq);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, dequeue strobe and response handshake
    always_comb begin
        state_d  = state_q;
        deq      = 1'b0;
        resp_enq = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    deq     = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                resp_enq = !RESP_FULL;
                if (!RESP_FULL) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request registers and read-data capture
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (deq)
                req_q <= req_d;
            if (state_q == ACCESS && !req_q.wr)
                rdata_q <= mem[req_q.addr];
        end
    end

    // Word memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && req_q.wr)
            mem[req_q.addr] <= req_q.wdata;
    end

    // Response data field: write-ack flag on top, read payload at the bottom
    always_comb begin
        resp_data                = '0;
        resp_data[DATA_WIDTH-1]  = req_q.wr;
        if (!req_q.wr)
            resp_data[PAYLOAD_WIDTH-1:0] = rdata_q;
    end

    // Source id in the top address bits steers the response back to its core.
    assign RESP_OUT = {req_q.src, {(ADDR_WIDTH-SRC_WIDTH){1'b0}}, resp_data};
    assign RESP_ENQ = resp_enq;

endmodule

// File: tb/tb_noc_mem_endpoint.sv
// Directed bench for noc_mem_endpoint: write/read, backpressure, FIFO full,
// address wrap, mid-operation reset and back-to-back throughput.
module tb_noc_mem_endpoint;

    logic         clk = 1'b0;
    logic         rst_l = 1'b0;
    logic         FIFO_ENQ = 1'b0;
    logic [143:0] FIFO_IN = '0;
    logic         FIFO_FULL;
    logic         RESP_ENQ;
    logic [143:0] RESP_OUT;
    logic         RESP_FULL = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int enq_cyc = 0;

    logic [143:0] rq [$];
    int           rc [$];

    localparam logic [127:0] WACK = {1'b1, 127'b0};

    noc_mem_endpoint dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .FIFO_ENQ  (FIFO_ENQ),
        .FIFO_IN   (FIFO_IN),
        .FIFO_FULL (FIFO_FULL),
        .RESP_ENQ  (RESP_ENQ),
        .RESP_OUT  (RESP_OUT),
        .RESP_FULL (RESP_FULL)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every accepted response is logged with its cycle.
    always begin
        @(negedge clk);
        #2;
        if (RESP_ENQ === 1'b1) begin
            rq.push_back(RESP_OUT);
            rc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] req(input logic [15:0] a, input logic wr,
                                         input logic [1:0] src, input logic [63:0] pl);
        logic [127:0] d;
        d          = '0;
        d[127]     = wr;
        d[126:125] = src;
        d[90]      = 1'b1;
        d[63:0]    = pl;
        return {a, d};
    endfunction

    // Called at a negedge; waits for space, enqueues for one cycle, returns at a negedge.
    task automatic enq(input logic [143:0] p);
        int n = 0;
        while (FIFO_FULL && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        assert (!FIFO_FULL) else begin
            n_fail++;
            $error("FAIL enq_wait observed=full expected=space");
        end
        FIFO_IN  = p;
        FIFO_ENQ = 1'b1;
        @(negedge clk);
        FIFO_ENQ = 1'b0;
        enq_cyc  = cyc;
    endtask

    task automatic get_resp(input string tag, input logic [143:0] exp, output int stamp);
        int n = 0;
        stamp = -1;
        while (rq.size() == 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        n_chk++;
        assert (rq.size() != 0) else begin
            n_fail++;
            $error("FAIL %s observed=no_response expected=response", tag);
        end
        if (rq.size() != 0) begin
            stamp = rc.pop_front();
            chk(tag, rq.pop_front(), exp);
        end
    endtask

    initial begin
        int st, st0, bad;
        int ts [6];
        logic [143:0] exp_bp;
        logic [143:0] exp_t [6];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_full", 144'(FIFO_FULL), 144'd0);
        chk("rst_enq",  144'(RESP_ENQ),  144'd0);
        chk("rst_out",  RESP_OUT,        144'd0);
        rst_l = 1'b1;
        @(negedge clk);

        // Write then read addr 5
        enq(req(16'h0005, 1'b1, 2'd2, 64'h0000_0000_DEAD_BEEF));
        st0 = enq_cyc;
        get_resp("wr_ack", {16'h8000, WACK}, st);
        chk("wr_lat", 144'(st - st0), 144'd2);
        @(negedge clk);
        enq(req(16'h0005, 1'b0, 2'd1, 64'h0));
        st0 = enq_cyc;
        get_resp("rd_data", {16'h4000, 64'h0, 64'h0000_0000_DEAD_BEEF}, st);
        chk("rd_lat", 144'(st - st0), 144'd2);

        // Backpressure: hold RESP_FULL for 10 cycles in RESP
        @(negedge clk);
        RESP_FULL = 1'b1;
        enq(req(16'h0005, 1'b0, 2'd3, 64'h0));
        st0 = enq_cyc;
        repeat (2) @(negedge clk);
        exp_bp = {16'hC000, 64'h0, 64'h0000_0000_DEAD_BEEF};
        #1;
        chk("bp_out", RESP_OUT, exp_bp);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) #1;
            if (RESP_ENQ !== 1'b0 || RESP_OUT !== exp_bp) bad++;
            @(negedge clk);
        end
        chk("bp_hold", 144'(bad), 144'd0);
        RESP_FULL = 1'b0;
        #1;
        chk("bp_enq", 144'(RESP_ENQ), 144'd1);
        get_resp("bp_resp", exp_bp, st);
        chk("bp_lat", 144'(st - st0), 144'd12);
        @(negedge clk);
        #1;
        chk("bp_idle", 144'(RESP_ENQ), 144'd0);

        // Address wrap: 0x0105 aliases 0x0005
        enq(req(16'h0105, 1'b1, 2'd0, 64'h11));
        get_resp("wrap_wack", {16'h0000, WACK}, st);
        @(negedge clk);
        enq(req(16'h0005, 1'b0, 2'd0, 64'h0));
        get_resp("wrap_rd", {16'h0000, 64'h0, 64'h11}, st);

        // Back-to-back throughput: 3 writes then 3 reads
        @(negedge clk);
        enq(req(16'h0020, 1'b1, 2'd0, 64'h0123_4567_89AB_CDEF));
        enq(req(16'h0021, 1'b1, 2'd1, 64'hFFFF_0000_1234_5678));
        enq(req(16'h0022, 1'b1, 2'd2, 64'hA5A5_A5A5_5A5A_5A5A));
        enq(req(16'h0020, 1'b0, 2'd3, 64'h0));
        enq(req(16'h0021, 1'b0, 2'd2, 64'h0));
        enq(req(16'h0022, 1'b0, 2'd1, 64'h0));
        exp_t[0] = {16'h0000, WACK};
        exp_t[1] = {16'h4000, WACK};
        exp_t[2] = {16'h8000, WACK};
        exp_t[3] = {16'hC000, 64'h0, 64'h0123_4567_89AB_CDEF};
        exp_t[4] = {16'h8000, 64'h0, 64'hFFFF_0000_1234_5678};
        exp_t[5] = {16'h4000, 64'h0, 64'hA5A5_A5A5_5A5A_5A5A};
        for (int i = 0; i < 6; i++)
            get_resp($sformatf("tp_resp%0d", i), exp_t[i], ts[i]);
        for (int i = 1; i < 6; i++)
            chk($sformatf("tp_gap%0d", i), 144'(ts[i] - ts[i-1]), 144'd3);

        // FIFO full with RESP_FULL held
        @(negedge clk);
        RESP_FULL = 1'b1;
        enq(req(16'h0022, 1'b0, 2'd0, 64'h0));
        enq(req(16'h0021, 1'b0, 2'd1, 64'h0));
        chk("ff_not_yet", 144'(FIFO_FULL), 144'd0);
        enq(req(16'h0020, 1'b0, 2'd2, 64'h0));
        chk("ff_full", 144'(FIFO_FULL), 144'd1);
        FIFO_IN  = req(16'h0020, 1'b1, 2'd0, 64'h0BAD);
        FIFO_ENQ = 1'b1;
        @(negedge clk);
        FIFO_ENQ = 1'b0;
        chk("ff_still", 144'(FIFO_FULL), 144'd1);
        repeat (3) @(negedge clk);
        RESP_FULL = 1'b0;
        get_resp("ff_r0", {16'h0000, 64'h0, 64'hA5A5_A5A5_5A5A_5A5A}, st);
        @(negedge clk);
        enq(req(16'h0105, 1'b0, 2'd3, 64'h0));
        get_resp("ff_r1", {16'h4000, 64'h0, 64'hFFFF_0000_1234_5678}, st);
        get_resp("ff_r2", {16'h8000, 64'h0, 64'h0123_4567_89AB_CDEF}, st);
        get_resp("ff_r3", {16'hC000, 64'h0, 64'h11}, st);
        repeat (8) @(negedge clk);
        chk("ff_no_extra", 144'(rq.size()), 144'd0);

        // Reset during ACCESS with one request queued
        enq(req(16'h0020, 1'b0, 2'd3, 64'h0));
        enq(req(16'h0021, 1'b0, 2'd1, 64'h0));
        rst_l = 1'b0;
        #1;
        chk("mid_rst_enq",  144'(RESP_ENQ),  144'd0);
        chk("mid_rst_out",  RESP_OUT,        144'd0);
        chk("mid_rst_full", 144'(FIFO_FULL), 144'd0);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_rst_drop", 144'(rq.size()), 144'd0);
        enq(req(16'h0020, 1'b0, 2'd2, 64'h0));
        get_resp("post_rst", {16'h8000, 64'h0, 64'h0123_4567_89AB_CDEF}, st);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
